// File: rtl/dpe_pkg.sv
// Shared types and helpers for the sigma.J dot-product engine.
package dpe_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} dpe_state_e;

  // Wide enough that +/-VECTOR_SIZE*max|J| never overflows.
  function automatic int dpe_result_width(input int vector_size, input int j_width);
    return $clog2(vector_size) + j_width + 1;
  endfunction

  // Zero- or sign-extends a j_width-bit element held in the LSBs of elem.
  function automatic logic [63:0] dpe_extend(input logic [31:0] elem, input int j_width,
                                             input bit j_signed);
    logic [63:0] ext;
    ext = {32'd0, elem};
    if (j_signed && elem[j_width-1]) ext = ext | ~((64'd1 << j_width) - 64'd1);
    return ext;
  endfunction

endpackage

// File: rtl/dpe_lane_sum.sv
// Combinational add/sub tree: sums LANES J elements, each negated when its sigma bit is 0.
module dpe_lane_sum
  import dpe_pkg::*;
#(
  parameter int LANES           = 16,
  parameter int J_ELEMENT_WIDTH = 4,
  parameter int J_SIGNED        = 0,
  parameter int RESULT_WIDTH    = 13
) (
  input  logic [LANES-1:0][J_ELEMENT_WIDTH-1:0] j,
  input  logic [LANES-1:0]                      sigma,
  output logic signed [RESULT_WIDTH-1:0]        sum
);

  localparam int LEAVES = 1 << $clog2(LANES);

  logic signed [RESULT_WIDTH-1:0] term [LANES];
  logic signed [RESULT_WIDTH-1:0] node [2*LEAVES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [RESULT_WIDTH-1:0] ext;
    assign ext     = RESULT_WIDTH'(dpe_extend(32'(j[i]), J_ELEMENT_WIDTH, J_SIGNED != 0));
    assign term[i] = sigma[i] ? ext : -ext;
  end

  // Heap-ordered tree: leaves at LEAVES.., root at node[1]; padding leaves are zero.
  always_comb begin
    for (int n = 0; n < 2*LEAVES; n++) node[n] = '0;
    for (int n = 0; n < LANES; n++) node[LEAVES+n] = term[n];
    for (int n = LEAVES-1; n >= 1; n--) node[n] = node[2*n] + node[2*n+1];
    sum = node[1];
  end

endmodule

// File: rtl/dot_product_engine.sv
// Streams one J column in LANES-wide chunks against a latched sigma vector and returns
// the signed dot product. Define DPE_PERF_CNT_EN to add the stall_cnt_o counter.
module dot_product_engine
  import dpe_pkg::*;
#(
  parameter int VECTOR_SIZE     = 256,
  parameter int LANES           = 16,
  parameter int J_ELEMENT_WIDTH = 4,
  parameter int J_SIGNED        = 0,
  parameter int RESULT_WIDTH    = dpe_result_width(VECTOR_SIZE, J_ELEMENT_WIDTH)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             start_valid_i,
  output logic                             start_ready_o,
  input  logic [VECTOR_SIZE-1:0]           sigma_i,
  input  logic                             j_valid_i,
  output logic                             j_ready_o,
  input  logic [LANES*J_ELEMENT_WIDTH-1:0] j_chunk_i,
  output logic                             dot_valid_o,
  input  logic                             dot_ready_i,
  output logic signed [RESULT_WIDTH-1:0]   dot_o,
  output logic                             busy_o
`ifdef DPE_PERF_CNT_EN
  ,
  output logic [31:0]                      stall_cnt_o
`endif
);

  localparam int CHUNKS = VECTOR_SIZE / LANES;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

  if ((LANES < 1) || (VECTOR_SIZE % LANES != 0)) begin : g_param_check
    $error("dot_product_engine: VECTOR_SIZE must be a nonzero multiple of LANES");
  end

  dpe_state_e                     state;
  logic [CW-1:0]                  cnt;
  logic [VECTOR_SIZE-1:0]         sigma;
  logic signed [RESULT_WIDTH-1:0] acc;
  logic signed [RESULT_WIDTH-1:0] lane_sum;
  logic [LANES-1:0]               lane_sigma;

  assign lane_sigma = sigma[cnt*LANES +: LANES];

  dpe_lane_sum #(
    .LANES           (LANES),
    .J_ELEMENT_WIDTH (J_ELEMENT_WIDTH),
    .J_SIGNED        (J_SIGNED),
    .RESULT_WIDTH    (RESULT_WIDTH)
  ) u_lane_sum (
    .j     (j_chunk_i),
    .sigma (lane_sigma),
    .sum   (lane_sum)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= '0;
      sigma <= '0;
      acc   <= '0;
    end else begin
      case (state)
        IDLE: if (start_valid_i) begin
          sigma <= sigma_i;
          acc   <= '0;
          cnt   <= '0;
          state <= ACCUM;
        end
        ACCUM: if (j_valid_i) begin
          acc <= acc + lane_sum;
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: if (dot_ready_i) begin
          // Result retiring and a new start in the same cycle skip IDLE entirely.
          if (start_valid_i) begin
            sigma <= sigma_i;
            acc   <= '0;
            cnt   <= '0;
            state <= ACCUM;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign start_ready_o = rst_ni && ((state == IDLE) || ((state == DONE) && dot_ready_i));
  assign j_ready_o     = (state == ACCUM);
  assign dot_valid_o   = (state == DONE);
  assign dot_o         = acc;
  assign busy_o        = (state != IDLE);

`ifdef DPE_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_o <= '0;
    end else if (((state == ACCUM) && !j_valid_i) || ((state == DONE) && !dot_ready_i)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dot_product_engine.sv
// Drives an unsigned-J and a signed-J engine with shared stimulus and checks both
// against a transaction-level dot-product model every cycle.
module tb_dot_product_engine;

  localparam int VS  = 8;
  localparam int LN  = 4;
  localparam int JW  = 4;
  localparam int RW  = 8;
  localparam int NCH = VS / LN;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            start_valid = 1'b0;
  logic [VS-1:0]   sigma = '0;
  logic            j_valid = 1'b0;
  logic [LN*JW-1:0] chunk = '0;
  logic            dot_ready = 1'b0;

  logic start_ready_u, j_ready_u, dot_valid_u, busy_u;
  logic start_ready_s, j_ready_s, dot_valid_s, busy_s;
  logic signed [RW-1:0] dot_u, dot_s;

  dot_product_engine #(.VECTOR_SIZE(VS), .LANES(LN), .J_ELEMENT_WIDTH(JW), .J_SIGNED(0)) u_dut_u (
    .clk_i(clk), .rst_ni(rst_n), .start_valid_i(start_valid), .start_ready_o(start_ready_u),
    .sigma_i(sigma), .j_valid_i(j_valid), .j_ready_o(j_ready_u), .j_chunk_i(chunk),
    .dot_valid_o(dot_valid_u), .dot_ready_i(dot_ready), .dot_o(dot_u), .busy_o(busy_u));

  dot_product_engine #(.VECTOR_SIZE(VS), .LANES(LN), .J_ELEMENT_WIDTH(JW), .J_SIGNED(1)) u_dut_s (
    .clk_i(clk), .rst_ni(rst_n), .start_valid_i(start_valid), .start_ready_o(start_ready_s),
    .sigma_i(sigma), .j_valid_i(j_valid), .j_ready_o(j_ready_s), .j_chunk_i(chunk),
    .dot_valid_o(dot_valid_s), .dot_ready_i(dot_ready), .dot_o(dot_s), .busy_o(busy_s));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Transaction model: phase 0 idle, 1 collecting a column, 2 result pending.
  int            ph = 0;
  logic [VS-1:0] msig;
  int            mcnt;
  int            mj [VS];
  int            exp_u, exp_s;
  int            v, sv;

  always @(posedge clk) begin
    if (!rst_n) begin
      ph = 0;
    end else begin
      case (ph)
        0: if (start_valid) begin msig = sigma; mcnt = 0; ph = 1; end
        1: if (j_valid) begin
          for (int i = 0; i < LN; i++) mj[mcnt*LN+i] = int'(chunk[i*JW +: JW]);
          mcnt++;
          if (mcnt == NCH) begin
            exp_u = 0;
            exp_s = 0;
            for (int k = 0; k < VS; k++) begin
              v  = mj[k];
              sv = (v >= (1 << (JW-1))) ? v - (1 << JW) : v;
              exp_u += msig[k] ? v : -v;
              exp_s += msig[k] ? sv : -sv;
            end
            ph = 2;
          end
        end
        2: if (dot_ready) begin
          if (start_valid) begin msig = sigma; mcnt = 0; ph = 1; end
          else ph = 0;
        end
        default: ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_start_ready_u", start_ready_u, 0);
      chk("rst_j_ready_u", j_ready_u, 0);
      chk("rst_dot_valid_u", dot_valid_u, 0);
      chk("rst_busy_u", busy_u, 0);
      chk("rst_dot_u", dot_u, 0);
      chk("rst_busy_s", busy_s, 0);
      chk("rst_dot_s", dot_s, 0);
    end else begin
      chk("start_ready_u", start_ready_u, (ph == 0) || (ph == 2 && dot_ready));
      chk("start_ready_s", start_ready_s, (ph == 0) || (ph == 2 && dot_ready));
      chk("j_ready_u", j_ready_u, ph == 1);
      chk("j_ready_s", j_ready_s, ph == 1);
      chk("dot_valid_u", dot_valid_u, ph == 2);
      chk("dot_valid_s", dot_valid_s, ph == 2);
      chk("busy_u", busy_u, ph != 0);
      chk("busy_s", busy_s, ph != 0);
      if (ph == 2) begin
        chk("dot_u", dot_u, exp_u);
        chk("dot_s", dot_s, exp_s);
      end
    end
  end

  logic [JW-1:0] jv [VS];
  int got_u, got_s, wait_cyc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_const(input int val);
    for (int k = 0; k < VS; k++) jv[k] = JW'(val);
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < VS; k++) jv[k] = JW'(k + 1);
  endtask

  task automatic do_start(input logic [VS-1:0] s);
    logic hs;
    start_valid = 1'b1;
    sigma = s;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      hs = start_ready_u;
      tick();
      if (hs) begin start_valid = 1'b0; return; end
    end
    chk("start_timeout", 0, 1);
    start_valid = 1'b0;
  endtask

  task automatic send_chunks(input int stall, input int n);
    logic hs;
    for (int c = 0; c < n; c++) begin
      if (c > 0) repeat (stall) tick();
      j_valid = 1'b1;
      for (int i = 0; i < LN; i++) chunk[i*JW +: JW] = jv[c*LN+i];
      hs = 1'b0;
      for (int t = 0; t < 50 && !hs; t++) begin
        @(negedge clk);
        hs = j_ready_u;
        tick();
      end
      if (!hs) chk("chunk_timeout", 0, 1);
      j_valid = 1'b0;
      chunk = '1;
    end
  endtask

  // Returns at a negedge with dot_valid high (or after a timeout).
  task automatic wait_valid();
    for (int t = 0; t < 50; t++) begin
      if (t > 0) @(posedge clk);
      @(negedge clk);
      if (dot_valid_u) begin
        wait_cyc = t;
        got_u = int'(dot_u);
        got_s = int'(dot_s);
        return;
      end
    end
    chk("valid_timeout", 0, 1);
    wait_cyc = -1;
  endtask

  task automatic release_dot(input int hold);
    @(posedge clk);
    #1;
    repeat (hold) tick();
    dot_ready = 1'b1;
    tick();
    dot_ready = 1'b0;
  endtask

  task automatic run_col(input logic [VS-1:0] s, input int stall, input int hold);
    do_start(s);
    send_chunks(stall, NCH);
    wait_valid();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    fill_const(15);
    run_col(8'hFF, 0, 0);
    chk("col1_latency", wait_cyc, 0);
    chk("col1_u", got_u, 120);
    chk("col1_s", got_s, -8);
    chk("model_col1_u", exp_u, 120);
    release_dot(0);

    run_col(8'h00, 0, 0);
    chk("col2_u", got_u, -120);
    chk("col2_s", got_s, 8);
    release_dot(0);

    fill_ramp();
    run_col(8'h0F, 0, 0);
    chk("col3_u", got_u, -16);
    chk("col3_s", got_s, 0);
    chk("model_col3_u", exp_u, -16);
    release_dot(0);

    fill_const(15);
    run_col(8'hFF, 3, 0);
    chk("stall_u", got_u, 120);
    release_dot(5);

    // Back-to-back: retire and restart in the same DONE cycle.
    run_col(8'hFF, 0, 0);
    chk("b2b_first_u", got_u, 120);
    @(posedge clk);
    #1;
    dot_ready = 1'b1;
    start_valid = 1'b1;
    sigma = 8'h0F;
    tick();
    dot_ready = 1'b0;
    start_valid = 1'b0;
    @(negedge clk);
    chk("b2b_busy", busy_u, 1);
    chk("b2b_j_ready", j_ready_u, 1);
    @(posedge clk);
    #1;
    fill_ramp();
    send_chunks(0, NCH);
    wait_valid();
    chk("b2b_second_u", got_u, -16);
    release_dot(0);

    // Reset after one chunk, then a clean column.
    fill_const(15);
    do_start(8'hFF);
    send_chunks(0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy_u, 0);
    chk("midrst_dot", dot_u, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    run_col(8'h00, 0, 0);
    chk("post_rst_u", got_u, -120);
    chk("post_rst_s", got_s, 8);
    release_dot(0);

    // Random columns; j_valid noise in IDLE and start_valid noise in ACCUM must be ignored.
    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < VS; k++) jv[k] = JW'($urandom_range(0, 15));
      j_valid = 1'b1;
      chunk = LN*JW'($urandom);
      repeat ($urandom_range(0, 2)) tick();
      do_start(VS'($urandom));
      j_valid = 1'b0;
      if (r % 3 == 0) begin
        start_valid = 1'b1;
        sigma = VS'($urandom);
      end
      send_chunks($urandom_range(0, 2), NCH);
      start_valid = 1'b0;
      wait_valid();
      release_dot($urandom_range(0, 3));
    end

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
